mem_bridge: RTL
===============

Name: mem_bridge

Overview:
- Sits directly downstream of the core datapath's memory port.
- Accepts one byte-addressed load/store request per transaction: address, RV32 funct3 size code, and unaligned store data.
- Converts it into a single word-aligned valid/ready bus beat with byte enables.
- Returns load data shifted and sign- or zero-extended to 32 bits, with a one-cycle done pulse and an error flag.

Parameters:
TIMEOUT, 16, bus wait-cycle limit before the transaction is abandoned with err; 0 disables the watchdog.
CNT_W, 5, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  request strobe; sampled only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  3  funct3 code: 0=B, 1=H, 2=W, 4=BU, 5=HU
req_wdata  in  32  store data, right-justified
rdata  out  32  extended load data; valid while done=1
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = timeout or trapped misalignment
busy  out  1  high whenever state != IDLE
bus_valid  out  1  bus request
bus_ready  in  1  bus accept/complete
bus_addr  out  32  {req_addr[31:2], 2'b00}
bus_we  out  1  write enable
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  raw read word; sampled on the handshake edge

Behaviour:
- Reset: rst synchronous, active-high.
  - State := IDLE.
  - bus_valid, done, err, busy := 0.
  - rdata := 0; watchdog counter := 0.
  - Reset mid-transaction aborts at the next edge: bus_valid low, no done pulse.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - start=1 latches we, addr, size and wdata into internal registers.
  - Next state is BUS, or RESP if the request is trapped (see Optional Feature).
- BUS:
  - bus_valid=1; bus_* outputs are driven from the latched registers and held stable until the handshake.
  - On the edge where bus_valid & bus_ready: capture the formatted load data into rdata (0 for stores), err:=0, go to RESP.
  - Otherwise the counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1 with bus_ready=0: rdata:=0, err:=1, go to RESP, bus_valid drops.
- RESP: done=1 for exactly one cycle, then IDLE. The counter clears on RESP→IDLE.
- Latency: start at edge t → bus_valid from t+1. If bus_ready=1 immediately, done is high in the cycle after the handshake edge, giving a minimum of 2 cycles from start to done. A new start is accepted in the cycle after done.
- start while busy is ignored, with no queueing.
- Store lane formatting:
  - B: be = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - W: be = 4'b1111; wdata unchanged.
- Loads drive the same be pattern with bus_we=0.
- Load formatting: shifted = bus_rdata >> (8*addr[1:0]), then:
  - B: sign-extend bits [7:0].
  - BU: zero-extend bits [7:0].
  - H: sign-extend bits [15:0].
  - HU: zero-extend bits [15:0].
  - W: unchanged.
- Codes 3, 6 and 7 are treated as W.
- Without trap, misaligned H ignores addr[0] and misaligned W ignores addr[1:0] (forced alignment).

Optional Feature:
MEM_BRIDGE_MISALIGN_TRAP_EN
- Defined:
  - In IDLE, a start whose request is misaligned, or uses an invalid size code (3, 6, 7), goes straight to RESP.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - bus_valid never asserts; done=1, err=1, rdata=0. Total latency is 1 cycle after start.
- Undefined: forced-alignment behaviour as above; err is asserted only by the watchdog.

Test Plan:
1. Store B, addr=0x103, wdata=0x000000A5, bus_ready tied 1 → bus_addr=0x100, be=4'b1000, bus_wdata=0xA5A5A5A5; done 2 cycles after start, err=0.
2. Load H, addr=0x202, bus_rdata=0x8001_7FFF → rdata=0xFFFF8001. Same transaction with HU → rdata=0x00008001. Load B at addr=0x200 → rdata=0xFFFFFFFF.
3. Load W with bus_ready held low for 3 cycles then high → bus_valid high and all bus_* stable for 4 cycles; done exactly one cycle after the handshake edge.
4. bus_ready never asserted, TIMEOUT=16 → bus_valid drops after 16 BUS cycles; done=1, err=1, rdata=0. The next start is accepted normally.
5. rst asserted during BUS → bus_valid=0 and busy=0 at the next edge, with no done pulse. start asserted while busy → ignored, and exactly one transaction occurs.
6. With MEM_BRIDGE_MISALIGN_TRAP_EN, load W at addr=0x102 → no bus_valid; done=1, err=1 in the cycle after start. Without the macro → bus_addr=0x100, be=4'b1111, err=0.

Source files
------------

// File: rtl/mem_bridge.sv
// mem_bridge: byte-addressed load/store request -> single word-aligned
// valid/ready bus beat with byte enables; formats load data back to 32 bits.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request strobe, sampled only when idle
//   req_we          1 = store, 0 = load
//   req_addr        byte address
//   req_size        RV32 funct3 size code (0=B,1=H,2=W,4=BU,5=HU; 3/6/7 as W)
//   req_wdata       right-justified store data
//   rdata           extended load data, valid while done=1
//   done            one-cycle completion pulse
//   err             valid with done: watchdog timeout or trapped request
//   busy            high whenever not idle
//   bus_valid/bus_ready        bus handshake
//   bus_addr/bus_we/bus_be/bus_wdata  bus request fields (held while bus_valid)
//   bus_rdata       raw read word, sampled on the handshake edge
//
// Parameters:
//   TIMEOUT  bus wait-cycle limit before abandoning with err (0 = no watchdog)
//   CNT_W    watchdog counter width, 2**CNT_W > TIMEOUT
//
// Build option: define MEM_BRIDGE_MISALIGN_TRAP_EN to reject misaligned
// H/HU/W requests and invalid size codes immediately with err, without a
// bus beat. Undefined: misaligned H/W are force-aligned.
module mem_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         size_q, size_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               is_byte, is_half;
  logic [1:0]         lane_off;
  logic [31:0]        shifted;
  logic [31:0]        load_fmt;
  logic               timeout_hit;
  logic               trap_req;

  // Size decode on the low two funct3 bits: x00 = byte, x01 = half,
  // everything else (2,3,6,7) is treated as a full word.
  assign is_byte = (size_q[1:0] == 2'b00);
  assign is_half = (size_q[1:0] == 2'b01);

  // Byte lane of the access after forced alignment.
  always_comb begin
    lane_off = 2'b00;
    if (is_byte) begin
      lane_off = addr_q[1:0];
    end else if (is_half) begin
      lane_off = {addr_q[1], 1'b0};
    end
  end

  always_comb begin
    bus_be    = 4'b1111;
    bus_wdata = wdata_q;
    if (is_byte) begin
      bus_be    = 4'b0001 << lane_off;
      bus_wdata = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      bus_wdata = {2{wdata_q[15:0]}};
    end
  end

  assign shifted = bus_rdata >> {lane_off, 3'b000};

  // size_q[2] selects the unsigned (BU/HU) variants.
  always_comb begin
    load_fmt = shifted;
    if (is_byte) begin
      load_fmt = size_q[2] ? {24'b0, shifted[7:0]}
                           : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_fmt = size_q[2] ? {16'b0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_BRIDGE_MISALIGN_TRAP_EN
  // Invalid codes: 3, 7 (low bits 11) and 6; misaligned H/HU or W.
  assign trap_req = (req_size[1:0] == 2'b11) || (req_size == 3'd6) ||
                    ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
`else
  assign trap_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          if (trap_req) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // A handshake on the last permitted cycle still wins over the watchdog.
        if (bus_ready) begin
          rdata_d = we_q ? '0 : load_fmt;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_valid = (state_q == S_BUS);
  assign done      = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_we    = we_q;

endmodule
